axi_burst_traffic_gen: RTL and testbench

- Parametrised AXI4 write/read-back traffic generator used as a bus stimulus master in front of the AXI-to-APB bridge.
- Issues NUM_BURSTS incrementing bursts of BURST_LEN beats with a deterministic data pattern.
- Optionally reads each burst back and compares the data.
- Reports completion, burst progress and an error count for self-checking benches and bring-up.

---
 rtl/axi_burst_traffic_gen_if.sv | 43 ++++
 rtl/axi_burst_traffic_gen.sv | 167 ++++++++++++++++
 tb/tb_axi_burst_traffic_gen.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_traffic_gen_if.sv
// AXI4 write/read channel bundle between the burst traffic generator and the slave under test.
interface axi_burst_traffic_gen_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_burst_traffic_gen.sv
// AXI4 burst traffic generator: writes NUM_BURSTS incrementing bursts with a counting
// data pattern, optionally reads each one back and counts response/data errors.
module axi_burst_traffic_gen #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                BURST_LEN  = 4,
  parameter int                NUM_BURSTS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'hAABB_CC00),
  parameter logic [31:0]       DATA_SEED  = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    verify_en,
  axi_burst_traffic_gen_if.master axi,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             burst_cnt,
  output logic [15:0]             err_cnt
);
  localparam logic [7:0]        LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * (DATA_W / 8));
  localparam logic [15:0]       NUM_B     = 16'(NUM_BURSTS);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        beat_reg, beat_next;
  logic [15:0]       burst_cnt_reg, burst_cnt_next;
  logic [15:0]       err_cnt_reg, err_cnt_next;
  logic              verify_reg, verify_next;
  logic              burst_end;
  logic              rd_last_beat;
  logic [1:0]        err_inc;
  logic [31:0]       pattern;
  logic [DATA_W-1:0] pattern_ext;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Same pattern serves as write data and as the read-back reference.
  assign pattern     = DATA_SEED + 32'(burst_cnt_reg) * 32'(BURST_LEN) + 32'(beat_reg);
  assign pattern_ext = DATA_W'(pattern);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= BASE_ADDR;
      beat_reg      <= 8'd0;
      burst_cnt_reg <= 16'd0;
      err_cnt_reg   <= 16'd0;
      verify_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      beat_reg      <= beat_next;
      burst_cnt_reg <= burst_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      verify_reg    <= verify_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    beat_next      = beat_reg;
    burst_cnt_next = burst_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    verify_next    = verify_reg;
    burst_end      = 1'b0;
    rd_last_beat   = (beat_reg == LAST_BEAT);
    err_inc        = 2'd0;

    axi.awvalid = 1'b0;
    axi.awaddr  = '0;
    axi.awlen   = 8'd0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.araddr  = '0;
    axi.arlen   = 8'd0;
    axi.rready  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next     = AW;
          verify_next    = verify_en;
          burst_cnt_next = 16'd0;
          err_cnt_next   = 16'd0;
          addr_next      = BASE_ADDR;
          beat_next      = 8'd0;
        end
      end
      AW: begin
        axi.awvalid = 1'b1;
        axi.awaddr  = addr_reg;
        axi.awlen   = LAST_BEAT;
        if (axi.awready) state_next = W;
      end
      W: begin
        axi.wvalid = 1'b1;
        axi.wdata  = pattern_ext;
        axi.wstrb  = '1;
        axi.wlast  = rd_last_beat;
        if (axi.wready) begin
          if (rd_last_beat) begin
            beat_next  = 8'd0;
            state_next = B;
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          err_inc = {1'b0, axi.bresp != 2'b00};
          if (verify_reg) state_next = AR;
          else            burst_end  = 1'b1;
        end
      end
      AR: begin
        axi.arvalid = 1'b1;
        axi.araddr  = addr_reg;
        axi.arlen   = LAST_BEAT;
        if (axi.arready) state_next = R;
      end
      R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          // A misplaced or missing rlast is its own error on top of any data/resp error.
          err_inc = {1'b0, (axi.rdata != pattern_ext) || (axi.rresp != 2'b00)}
                  + {1'b0, axi.rlast != rd_last_beat};
          if (axi.rlast || rd_last_beat) begin
            beat_next = 8'd0;
            burst_end = 1'b1;
          end else begin
            beat_next = beat_reg + 8'd1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    err_cnt_next = sat_add(err_cnt_next, err_inc);

    if (burst_end) begin
      burst_cnt_next = burst_cnt_reg + 16'd1;
      addr_next      = addr_reg + ADDR_STEP;
      state_next     = (burst_cnt_reg + 16'd1 == NUM_B) ? DONE : AW;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign burst_cnt = burst_cnt_reg;
  assign err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_axi_burst_traffic_gen.sv
// Directed bench for axi_burst_traffic_gen: memory-model slave with stall/error knobs,
// plus a BURST_LEN=1 instance against an always-ready slave.
module tb_axi_burst_traffic_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        verify_en = 1'b0;
  logic        busy, done;
  logic [15:0] burst_cnt, err_cnt;
  logic        start1 = 1'b0;
  logic        busy1, done1;
  logic [15:0] burst_cnt1, err_cnt1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_burst_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axi_burst_traffic_gen_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  axi_burst_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .verify_en(verify_en),
    .axi(bus.master), .busy(busy), .done(done),
    .burst_cnt(burst_cnt), .err_cnt(err_cnt)
  );

  axi_burst_traffic_gen #(.BURST_LEN(1), .NUM_BURSTS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .verify_en(1'b0),
    .axi(bus1.master), .busy(busy1), .done(done1),
    .burst_cnt(burst_cnt1), .err_cnt(err_cnt1)
  );

  assign bus1.awready = 1'b1;
  assign bus1.wready  = 1'b1;
  assign bus1.bvalid  = 1'b1;
  assign bus1.bresp   = 2'b00;
  assign bus1.arready = 1'b1;
  assign bus1.rdata   = 32'd0;
  assign bus1.rresp   = 2'b00;
  assign bus1.rlast   = 1'b0;
  assign bus1.rvalid  = 1'b0;

  // Slave knobs and state
  bit          stall_en = 1'b0;
  int          bresp_err_idx = -1, corrupt_idx = -1, early_idx = -1, early_beat = 1;
  logic        slv_clr = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cur_waddr, cur_raddr;
  int          wbeat, rbeat, b_pend, b_idx, r_idx, stab_err;
  logic        r_active;
  logic        aw_hold, w_hold, ar_hold;
  logic [31:0] aw_hold_addr, w_hold_data, ar_hold_addr;
  logic        w_hold_last;
  logic [31:0] aw_log[$], ar_log[$], w_log[$];
  logic        wlast_log[$];
  logic [31:0] w1_log[$];
  logic        wl1_log[$];
  logic [7:0]  awlen1_log[$];

  // Handshakes are recorded at the negedge preceding the edge that completes them.
  always @(negedge clk) begin
    if (!rst_n || slv_clr) begin
      wbeat = 0; rbeat = 0; b_pend = 0; b_idx = 0; r_idx = 0; r_active = 1'b0;
      aw_hold = 1'b0; w_hold = 1'b0; ar_hold = 1'b0;
      if (slv_clr) begin
        stab_err = 0;
        aw_log.delete(); ar_log.delete(); w_log.delete(); wlast_log.delete();
      end
    end else begin
      if (aw_hold && (!bus.awvalid || bus.awaddr !== aw_hold_addr)) stab_err++;
      if (w_hold && (!bus.wvalid || bus.wdata !== w_hold_data || bus.wlast !== w_hold_last)) stab_err++;
      if (ar_hold && (!bus.arvalid || bus.araddr !== ar_hold_addr)) stab_err++;
      aw_hold = bus.awvalid && !bus.awready; aw_hold_addr = bus.awaddr;
      w_hold  = bus.wvalid && !bus.wready;   w_hold_data = bus.wdata; w_hold_last = bus.wlast;
      ar_hold = bus.arvalid && !bus.arready; ar_hold_addr = bus.araddr;
      if (bus.awvalid && bus.awready) begin
        aw_log.push_back(bus.awaddr);
        cur_waddr = bus.awaddr;
        $display("AW addr=%08h len=%0d", bus.awaddr, bus.awlen);
      end
      if (bus.wvalid && bus.wready) begin
        mem[cur_waddr + 32'(4 * wbeat)] = bus.wdata;
        w_log.push_back(bus.wdata);
        wlast_log.push_back(bus.wlast);
        wbeat++;
        if (bus.wlast) begin wbeat = 0; b_pend++; end
      end
      if (bus.bvalid && bus.bready) begin b_pend--; b_idx++; end
      if (bus.arvalid && bus.arready) begin
        ar_log.push_back(bus.araddr);
        cur_raddr = bus.araddr; r_active = 1'b1; rbeat = 0;
        $display("AR addr=%08h len=%0d", bus.araddr, bus.arlen);
      end
      if (bus.rvalid && bus.rready) begin
        if (bus.rlast) begin r_active = 1'b0; r_idx++; end
        else rbeat++;
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] a;
    #1;
    if (!rst_n) begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0; bus.bresp = 2'b00;
      bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    end else begin
      bus.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.bvalid  = (b_pend > 0);
      bus.bresp   = (b_idx == bresp_err_idx) ? 2'b10 : 2'b00;
      bus.rresp   = 2'b00;
      if (r_active) begin
        a = cur_raddr + 32'(4 * rbeat);
        bus.rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.rdata  = (mem.exists(a) ? mem[a] : 32'hDEAD_BEEF)
                   ^ ((r_idx == corrupt_idx && rbeat == 1) ? 32'h1 : 32'h0);
        bus.rlast  = (rbeat == 3) || (r_idx == early_idx && rbeat == early_beat);
      end else begin
        bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rlast = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.wvalid && bus1.wready) begin
      w1_log.push_back(bus1.wdata);
      wl1_log.push_back(bus1.wlast);
    end
    if (bus1.awvalid && bus1.awready) awlen1_log.push_back(bus1.awlen);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic ver, input string tag);
    slv_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    slv_clr = 1'b0;
    verify_en = ver;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    verify_en = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_burst_cnt_clr"}, 64'(burst_cnt), 64'd0);
  endtask

  task automatic wait_done(input int budget, input string tag, input int poke_at);
    int cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_awvalid", 64'(bus.awvalid), 64'd0);
    check("rst_wvalid", 64'(bus.wvalid), 64'd0);
    check("rst_awaddr", 64'(bus.awaddr), 64'd0);
    check("rst_cnts", 64'({burst_cnt, err_cnt}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write-only run, second start pulse mid-run must be ignored
    start_run(1'b0, "wr");
    wait_done(500, "wr", 10);
    check("wr_aw_count", 64'(aw_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("wr_awaddr%0d", i), 64'(aw_log[i]), 64'(32'hAABB_CC00 + 32'(16 * i)));
    check("wr_w_count", 64'(w_log.size()), 64'd32);
    for (int n = 0; n < 32; n++) begin
      check($sformatf("wr_wdata%0d", n), 64'(w_log[n]), 64'(32'h1000_0000 + 32'(n)));
      check($sformatf("wr_wlast%0d", n), 64'(wlast_log[n]), 64'(n % 4 == 3));
    end
    check("wr_ar_count", 64'(ar_log.size()), 64'd0);
    check("wr_burst_cnt", 64'(burst_cnt), 64'd8);
    check("wr_err_cnt", 64'(err_cnt), 64'd0);

    // Write + read-back against the memory model
    start_run(1'b1, "vr");
    wait_done(1000, "vr", 0);
    check("vr_ar_count", 64'(ar_log.size()), 64'd8);
    check("vr_araddr7", 64'(ar_log[7]), 64'h0000_0000_AABB_CC70);
    check("vr_burst_cnt", 64'(burst_cnt), 64'd8);
    check("vr_err_cnt", 64'(err_cnt), 64'd0);

    // Random stalls on every slave-side handshake
    stall_en = 1'b1;
    start_run(1'b1, "st");
    wait_done(4000, "st", 0);
    stall_en = 1'b0;
    check("st_w_count", 64'(w_log.size()), 64'd32);
    for (int n = 0; n < 32; n++)
      check($sformatf("st_wdata%0d", n), 64'(w_log[n]), 64'(32'h1000_0000 + 32'(n)));
    check("st_stable", 64'(stab_err), 64'd0);
    check("st_burst_cnt", 64'(burst_cnt), 64'd8);
    check("st_err_cnt", 64'(err_cnt), 64'd0);

    // SLVERR on burst 3, corrupted read beat in burst 5
    bresp_err_idx = 2;
    corrupt_idx = 4;
    start_run(1'b1, "er");
    wait_done(1000, "er", 0);
    bresp_err_idx = -1;
    corrupt_idx = -1;
    check("er_burst_cnt", 64'(burst_cnt), 64'd8);
    check("er_err_cnt", 64'(err_cnt), 64'd2);

    // Early rlast on the second beat of the first read burst
    early_idx = 0;
    early_beat = 1;
    start_run(1'b1, "el");
    wait_done(1000, "el", 0);
    early_idx = -1;
    check("el_ar_count", 64'(ar_log.size()), 64'd8);
    check("el_burst_cnt", 64'(burst_cnt), 64'd8);
    check("el_err_cnt", 64'(err_cnt), 64'd1);

    // Asynchronous reset while the third W beat is on the bus
    start_run(1'b0, "rs");
    cyc = 0;
    while (!(bus.wvalid && bus.wdata === 32'h1000_0002) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rs_reached_beat2", 64'(cyc < 100), 64'd1);
    check("rs_wlast_beat2", 64'(bus.wlast), 64'd0);
    check("rs_wstrb", 64'(bus.wstrb), 64'hF);
    #2 rst_n = 1'b0;
    #1;
    check("rs_wvalid_async", 64'(bus.wvalid), 64'd0);
    check("rs_wdata_async", 64'(bus.wdata), 64'd0);
    check("rs_valids_async", 64'({bus.awvalid, bus.arvalid, bus.bready, bus.rready, busy, done}), 64'd0);
    check("rs_cnt_async", 64'(burst_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(1'b0, "rr");
    wait_done(500, "rr", 0);
    check("rr_first_aw", 64'(aw_log[0]), 64'h0000_0000_AABB_CC00);
    check("rr_burst_cnt", 64'(burst_cnt), 64'd8);

    // BURST_LEN=1 instance
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    while (!done1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b1_done_seen", 64'(done1), 64'd1);
    check("b1_w_count", 64'(w1_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < w1_log.size(); i++) begin
      check($sformatf("b1_wlast%0d", i), 64'(wl1_log[i]), 64'd1);
      check($sformatf("b1_wdata%0d", i), 64'(w1_log[i]), 64'(32'h1000_0000 + 32'(i)));
      check($sformatf("b1_awlen%0d", i), 64'(awlen1_log[i]), 64'd0);
    end
    check("b1_burst_cnt", 64'(burst_cnt1), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
